// File: rtl/ave8_core.sv
// ave8_core: 8-tap moving-average engine.
//
// Pops one unsigned 8-bit sample from the input FIFO and folds it into a
// running sum over the last 8 samples. It then pushes the truncated average
// (sum / 8) to the result FIFO with a single-cycle write strobe.
//
// Parameters:
//   SKIP_FILL     1 = no results until 8 samples have arrived since reset,
//                 0 = a result for every sample (history starts zero-filled)
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   rst           synchronous active-low reset
//   in0           head of the input FIFO, valid while in0_empty = 0
//   in0_empty     1 = input FIFO has no sample
//   in0_rd        read-increment request (FIFO pops on the edge it is 1)
//   ave8_ret      registered average, held between strobes
//   ave8_ret_we   write-increment strobe for ave8_ret
//   ave8_ret_full 1 = result FIFO cannot accept a value

module ave8_core #(
  parameter int SKIP_FILL = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in0,
  input  logic       in0_empty,
  output logic       in0_rd,
  output logic [7:0] ave8_ret,
  output logic       ave8_ret_we,
  input  logic       ave8_ret_full
);

  typedef enum logic [1:0] {
    S_RD  = 2'd0,
    S_ACC = 2'd1,
    S_WR  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  hist_reg [8];
  logic [10:0] sum_reg, sum_next;
  logic [2:0]  ptr_reg;
  logic [3:0]  fill_cnt_reg, fill_cnt_next;
  logic [7:0]  smp_reg;
  logic [7:0]  ave8_ret_reg;

  // The oldest sample sits at hist_reg[ptr_reg]; swapping it for the new one
  // keeps sum_reg equal to the sum of the last 8 samples. The true result is
  // never negative and fits in 11 bits, so modulo-2^11 arithmetic is exact.
  assign sum_next      = sum_reg + {3'b000, smp_reg} - {3'b000, hist_reg[ptr_reg]};
  assign fill_cnt_next = (fill_cnt_reg == 4'd8) ? 4'd8 : fill_cnt_reg + 4'd1;

  // Strobes are gated by rst so that no FIFO pops or pushes happen while the
  // core is being reset and the outputs are quiet in the reset state.
  always_comb begin
    state_next  = state_reg;
    in0_rd      = 1'b0;
    ave8_ret_we = 1'b0;
    case (state_reg)
      S_RD: begin
        in0_rd = rst & ~in0_empty;
        if (!in0_empty) begin
          state_next = S_ACC;
        end
      end
      S_ACC: begin
        if (SKIP_FILL != 0 && fill_cnt_next < 4'd8) begin
          state_next = S_RD;
        end else begin
          state_next = S_WR;
        end
      end
      S_WR: begin
        ave8_ret_we = rst & ~ave8_ret_full;
        if (!ave8_ret_full) begin
          state_next = S_RD;
        end
      end
      default: begin
        state_next = S_RD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= S_RD;
      sum_reg      <= '0;
      ptr_reg      <= '0;
      fill_cnt_reg <= '0;
      smp_reg      <= '0;
      ave8_ret_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (in0_rd) begin
        smp_reg <= in0;
      end
      if (state_reg == S_ACC) begin
        sum_reg      <= sum_next;
        ptr_reg      <= ptr_reg + 3'd1;
        fill_cnt_reg <= fill_cnt_next;
        ave8_ret_reg <= sum_next[10:3];
      end
    end
  end

  // One register per history slot; only the slot under the pointer is
  // overwritten during accumulation.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_hist
      always_ff @(posedge clk) begin
        if (!rst) begin
          hist_reg[gi] <= '0;
        end else if (state_reg == S_ACC && ptr_reg == 3'(gi)) begin
          hist_reg[gi] <= smp_reg;
        end
      end
    end
  endgenerate

  assign ave8_ret = ave8_ret_reg;

endmodule

// File: tb/tb_ave8_core.sv
// Testbench for ave8_core. It runs two instances side by side: dut_a with
// SKIP_FILL=0 and dut_b with SKIP_FILL=1. Each instance is fed from its own
// sample queue. A reference model keeps the list of samples accepted since
// reset and computes the expected average from that list.

module tb_ave8_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] in0_a, in0_b;
  logic       empty_a, empty_b;
  logic       rd_a, rd_b;
  logic [7:0] ret_a, ret_b;
  logic       we_a, we_b;
  logic       full;

  ave8_core #(.SKIP_FILL(0)) dut_a (
    .clk(clk), .rst(rst), .in0(in0_a), .in0_empty(empty_a), .in0_rd(rd_a),
    .ave8_ret(ret_a), .ave8_ret_we(we_a), .ave8_ret_full(full)
  );

  ave8_core #(.SKIP_FILL(1)) dut_b (
    .clk(clk), .rst(rst), .in0(in0_b), .in0_empty(empty_b), .in0_rd(rd_b),
    .ave8_ret(ret_b), .ave8_ret_we(we_b), .ave8_ret_full(full)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic stall = 1'b0;
  logic full_req = 1'b0;

  int src_a[$], src_b[$];     // samples waiting in the input FIFOs
  int hist_a[$], hist_b[$];   // samples accepted since reset
  int exp_a[$], exp_b[$];     // results owed to the sink
  int rd_cyc_a, rd_cyc_b;
  bit bp_a, bp_b;
  int strobes_a, strobes_b, last_a, last_b, pops_a;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int avg_last8(input int h[$]);
    int s = 0;
    int n = h.size();
    for (int i = (n > 8) ? n - 8 : 0; i < n; i++) s += h[i];
    return s / 8;
  endfunction

  // One clock cycle: drive the inputs at the falling edge, observe the
  // outputs 1 time unit later, and update the model. Then let the rising
  // edge happen.
  task automatic cycle();
    @(negedge clk);
    full    = full_req;
    in0_a   = (src_a.size() != 0) ? 8'(src_a[0]) : 8'h00;
    in0_b   = (src_b.size() != 0) ? 8'(src_b[0]) : 8'h00;
    empty_a = stall || (src_a.size() == 0);
    empty_b = stall || (src_b.size() == 0);
    #1;
    if (!rst) begin
      check("a_rd_in_reset", int'(rd_a), 0);
      check("a_we_in_reset", int'(we_a), 0);
      check("b_rd_in_reset", int'(rd_b), 0);
      check("b_we_in_reset", int'(we_b), 0);
    end else begin
      if (empty_a) check("a_rd_when_empty", int'(rd_a), 0);
      if (empty_b) check("b_rd_when_empty", int'(rd_b), 0);
      if (full) begin
        check("a_we_when_full", int'(we_a), 0);
        check("b_we_when_full", int'(we_b), 0);
      end
      // instance A
      if (rd_a && !empty_a) begin
        check("a_rd_while_pending", exp_a.size(), 0);
        hist_a.push_back(src_a.pop_front());
        pops_a++;
        rd_cyc_a = cyc;
        bp_a = 1'b0;
        exp_a.push_back(avg_last8(hist_a));
      end
      if (we_a) begin
        strobes_a++;
        last_a = int'(ret_a);
        if (exp_a.size() == 0) check("a_spurious_we", 1, 0);
        else begin
          check("a_ret", int'(ret_a), exp_a.pop_front());
          if (!bp_a) check("a_latency", cyc - rd_cyc_a, 2);
        end
      end else if (exp_a.size() != 0 && cyc - rd_cyc_a >= 2) begin
        if (full) check("a_hold", int'(ret_a), exp_a[0]);
        else check("a_we_due", int'(we_a), 1);
      end
      // instance B: only results once 8 samples have been seen
      if (rd_b && !empty_b) begin
        check("b_rd_while_pending", exp_b.size(), 0);
        hist_b.push_back(src_b.pop_front());
        rd_cyc_b = cyc;
        bp_b = 1'b0;
        if (hist_b.size() >= 8) exp_b.push_back(avg_last8(hist_b));
      end
      if (we_b) begin
        strobes_b++;
        last_b = int'(ret_b);
        if (exp_b.size() == 0) check("b_spurious_we", 1, 0);
        else begin
          check("b_ret", int'(ret_b), exp_b.pop_front());
          if (!bp_b) check("b_latency", cyc - rd_cyc_b, 2);
        end
      end else if (exp_b.size() != 0 && cyc - rd_cyc_b >= 2) begin
        if (full) check("b_hold", int'(ret_b), exp_b[0]);
        else check("b_we_due", int'(we_b), 1);
      end
      if (full) begin
        bp_a = 1'b1;
        bp_b = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic do_reset(input int n);
    src_a.delete();
    src_b.delete();
    rst = 1'b0;
    repeat (n) cycle();
    rst = 1'b1;
    hist_a.delete(); hist_b.delete();
    exp_a.delete();  exp_b.delete();
    strobes_a = 0; strobes_b = 0; last_a = 0; last_b = 0; pops_a = 0;
    bp_a = 1'b0; bp_b = 1'b0;
    @(negedge clk);
    empty_a = 1'b1;
    empty_b = 1'b1;
    full = full_req;
    #1;
    check("rst_ret_a", int'(ret_a), 0);
    check("rst_ret_b", int'(ret_b), 0);
    check("rst_rd_a", int'(rd_a), 0);
    check("rst_we_a", int'(we_a), 0);
    check("rst_we_b", int'(we_b), 0);
  endtask

  task automatic push_both(input int v);
    src_a.push_back(v);
    src_b.push_back(v);
  endtask

  task automatic run_idle(input int max_cycles);
    int n = 0;
    while ((src_a.size() != 0 || src_b.size() != 0 ||
            exp_a.size() != 0 || exp_b.size() != 0) && n < max_cycles) begin
      cycle();
      n++;
    end
    if (n >= max_cycles) check("idle_timeout", n, 0);
    repeat (3) cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0;
    in0_a = '0; in0_b = '0;
    empty_a = 1'b1; empty_b = 1'b1; full = 1'b0;

    // Constant stream of 255: 31,63,...,255,255
    do_reset(2);
    repeat (9) push_both(255);
    run_idle(200);
    check("const_strobes", strobes_a, 9);
    check("const_last", last_a, 255);
    $display("const stream: %0d strobes, last %0d", strobes_a, last_a);

    // Ramp down through wrap-around: 8 x8 then 0 x8
    do_reset(1);
    repeat (8) push_both(8);
    repeat (8) push_both(0);
    run_idle(300);
    check("wrap_strobes", strobes_a, 16);
    check("wrap_last", last_a, 0);
    $display("wrap: %0d strobes, last %0d", strobes_a, last_a);

    // 1..10: SKIP_FILL instance gives exactly 4,5,6
    do_reset(1);
    for (int i = 1; i <= 10; i++) push_both(i);
    run_idle(300);
    check("skip_strobes_b", strobes_b, 3);
    check("skip_last_b", last_b, 6);
    check("skip_strobes_a", strobes_a, 10);
    $display("skip fill: b strobes %0d last %0d", strobes_b, last_b);

    // Input empty stall mid-stream
    do_reset(1);
    for (int i = 0; i < 4; i++) push_both($urandom_range(0, 255));
    run_idle(200);
    stall = 1'b1;
    push_both(200);
    push_both(17);
    repeat (10) begin
      cycle();
      check("stall_rd_a", int'(rd_a), 0);
      check("stall_we_a", int'(we_a), 0);
      check("stall_we_b", int'(we_b), 0);
    end
    stall = 1'b0;
    run_idle(200);
    check("stall_strobes_a", strobes_a, 6);
    $display("stall: a strobes %0d last %0d", strobes_a, last_a);

    // Output backpressure for 5 cycles while a result is pending
    do_reset(1);
    for (int i = 0; i < 3; i++) push_both(40 * (i + 1));
    n = 0;
    while (exp_a.size() == 0 && n < 50) begin cycle(); n++; end
    if (n >= 50) check("bp_wait_timeout", n, 0);
    full_req = 1'b1;
    repeat (5) cycle();
    full_req = 1'b0;
    run_idle(200);
    check("bp_strobes_a", strobes_a, 3);
    check("bp_last_a", last_a, 30);
    $display("backpressure: a strobes %0d last %0d", strobes_a, last_a);

    // Randomized stream with random stalls and backpressure
    do_reset(1);
    for (int i = 0; i < 60; i++) push_both($urandom_range(0, 255));
    n = 0;
    while ((src_a.size() != 0 || src_b.size() != 0 ||
            exp_a.size() != 0 || exp_b.size() != 0) && n < 3000) begin
      stall = ($urandom_range(0, 3) == 0);
      full_req = ($urandom_range(0, 3) == 0);
      cycle();
      n++;
    end
    stall = 1'b0;
    full_req = 1'b0;
    if (n >= 3000) check("random_timeout", n, 0);
    run_idle(100);
    check("random_strobes_a", strobes_a, 60);
    check("random_strobes_b", strobes_b, 53);
    $display("random: a strobes %0d, b strobes %0d", strobes_a, strobes_b);

    // Reset while the fifth sample of 200 is being accumulated
    do_reset(1);
    repeat (5) push_both(200);
    n = 0;
    while (pops_a < 5 && n < 100) begin cycle(); n++; end
    if (n >= 100) check("mid_rst_timeout", n, 0);
    do_reset(1);
    push_both(80);
    run_idle(100);
    check("post_rst_strobes_a", strobes_a, 1);
    check("post_rst_val_a", last_a, 10);
    check("post_rst_strobes_b", strobes_b, 0);
    $display("reset mid-op: a strobes %0d value %0d", strobes_a, last_a);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
